// File: rtl/lfsr_share_arb.sv
// Round-robin arbiter that hands a random nibble from a shared 4-bit Fibonacci LFSR to each granted requester.
// Optional build macro LFSR_SHARE_ARB_LOCKUP_DET_EN adds all-zero LFSR detection, SEED reload and a lockup pulse.
module lfsr_share_arb #(
    parameter logic [3:0] SEED = 4'hF,
    parameter int         NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            seed_load,
    input  logic [3:0]      seed_val,
    output logic [NREQ-1:0] gnt,
    output logic            valid,
    output logic [3:0]      data,
    output logic            busy,
    output logic [7:0]      grant_cnt
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
    ,
    output logic            lockup
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_lfsr;
    logic [IW-1:0] r_winner;
    logic [IW-1:0] r_last;
    logic [7:0]    r_cnt;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
    logic          r_lockup;
`endif

    logic [IW-1:0] w_pick;
    logic          w_found;
    logic          w_any;
    logic [3:0]    w_lfsr_next;

    assign w_any       = |req;
    assign w_lfsr_next = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

    // Round-robin search: first set request at or after last winner + 1, wrapping.
    // NOTE: every variable gets a default before the loop so no path leaves a value held, which would infer a latch.
    always_comb begin
        int v_idx;
        w_pick  = '0;
        w_found = 1'b0;
        v_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (int'(r_last) + 1 + k) % NREQ;
            if (!w_found && req[v_idx]) begin
                w_pick  = v_idx[IW-1:0];
                w_found = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: all state, including the LFSR and last winner, is asynchronously reset; there is no memory array here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_lfsr   <= SEED;
            r_winner <= '0;
            r_last   <= IW'(NREQ - 1);
            r_cnt    <= 8'h00;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
            r_lockup <= 1'b0;
`endif
        end else begin
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
            r_lockup <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
                    // An all-zero LFSR never leaves zero; recover before arbitrating again.
                    if (r_lfsr == 4'h0) begin
                        r_lfsr   <= SEED;
                        r_lockup <= 1'b1;
                    end else
`endif
                    if (seed_load) begin
                        r_lfsr <= seed_val;
                    end else if (en && w_any) begin
                        r_winner <= w_pick;
                        r_state  <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    r_state <= ST_GRANT;
                end
                ST_GRANT: begin
                    r_lfsr  <= w_lfsr_next;
                    r_cnt   <= r_cnt + 8'h01;
                    r_last  <= r_winner;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Grant outputs decode straight from state so reset clears them without a clock.
    always_comb begin
        gnt = '0;
        if (r_state == ST_GRANT) begin
            gnt[r_winner] = 1'b1;
        end
    end

    assign valid     = (r_state == ST_GRANT);
    assign data      = valid ? r_lfsr : 4'h0;
    assign busy      = (r_state != ST_IDLE);
    assign grant_cnt = r_cnt;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
    assign lockup    = r_lockup;
`endif

endmodule

// File: tb/tb_lfsr_share_arb.sv
// Directed self-checking bench for lfsr_share_arb (NREQ=4, SEED=F); follows the lockup macro if defined.
module tb_lfsr_share_arb;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       seed_load;
    logic [3:0] seed_val;
    logic [3:0] gnt;
    logic       valid;
    logic [3:0] data;
    logic       busy;
    logic [7:0] grant_cnt;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
    logic       lockup;
`endif

    int errors = 0;
    int checks = 0;

    lfsr_share_arb #(.SEED(4'hF), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt),
        .valid     (valid),
        .data      (data),
        .busy      (busy),
        .grant_cnt (grant_cnt)
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
        ,
        .lockup    (lockup)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then let outputs settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        en        = 1'b0;
        req       = 4'b0000;
        seed_load = 1'b0;
        seed_val  = 4'h0;
        #2;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt, valid, data, busy} !== 10'b0) begin
            $display("FAIL reset_outputs: got gnt=%b valid=%b data=%h busy=%b, want all zero", gnt, valid, data, busy);
            errors++;
        end
        checks++;
        if (grant_cnt !== 8'h00) begin
            $display("FAIL reset_cnt: got %h want 00", grant_cnt);
            errors++;
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        en  = 1'b1;
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
            $display("FAIL single_arb: got gnt=%b busy=%b want gnt=0000 busy=1", gnt, busy);
            errors++;
        end
        tick();
        checks++;
        if (gnt !== 4'b0001 || valid !== 1'b1 || data !== 4'hF) begin
            $display("FAIL single_grant1: got gnt=%b valid=%b data=%h want 0001 1 f", gnt, valid, data);
            errors++;
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || grant_cnt !== 8'd1) begin
            $display("FAIL single_idle: got gnt=%b busy=%b cnt=%0d want 0000 0 1", gnt, busy, grant_cnt);
            errors++;
        end
        req = 4'b0001;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0001 || data !== 4'hE) begin
            $display("FAIL single_grant2: got gnt=%b data=%h want 0001 e", gnt, data);
            errors++;
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant_cnt !== 8'd2) begin
            $display("FAIL single_cnt: got %0d want 2", grant_cnt);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_d [5] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        int n;
        do_reset();
        en  = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (gnt === 4'b0000 && n < 8);
            checks++;
            if (n !== ((i == 0) ? 2 : 3)) begin
                $display("FAIL rr_latency%0d: got %0d cycles want %0d", i, n, (i == 0) ? 2 : 3);
                errors++;
            end
            checks++;
            if (gnt !== exp_g[i] || data !== exp_d[i]) begin
                $display("FAIL rr_grant%0d: got gnt=%b data=%h want %b %h", i, gnt, data, exp_g[i], exp_d[i]);
                errors++;
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant_cnt !== 8'd5) begin
            $display("FAIL rr_cnt: got %0d want 5", grant_cnt);
            errors++;
        end
    endtask

    task automatic test_seed_load();
        do_reset();
        en        = 1'b1;
        req       = 4'b0010;
        seed_load = 1'b1;
        seed_val  = 4'h8;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL seed_noarb: got busy=%b want 0", busy);
            errors++;
        end
        seed_load = 1'b0;
        tick();
        seed_load = 1'b1;
        seed_val  = 4'h3;
        tick();
        checks++;
        if (gnt !== 4'b0010 || data !== 4'h8) begin
            $display("FAIL seed_grant1: got gnt=%b data=%h want 0010 8", gnt, data);
            errors++;
        end
        seed_load = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0010 || data !== 4'h1) begin
            $display("FAIL seed_grant2: got gnt=%b data=%h want 0010 1", gnt, data);
            errors++;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_lockup();
        do_reset();
        en        = 1'b1;
        seed_load = 1'b1;
        seed_val  = 4'h0;
        tick();
        seed_load = 1'b0;
        req       = 4'b0001;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
        tick();
        checks++;
        if (lockup !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL lockup_pulse: got lockup=%b busy=%b want 1 0", lockup, busy);
            errors++;
        end
        tick();
        checks++;
        if (lockup !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL lockup_clear: got lockup=%b busy=%b want 0 1", lockup, busy);
            errors++;
        end
        tick();
        checks++;
        if (gnt !== 4'b0001 || data !== 4'hF) begin
            $display("FAIL lockup_grant: got gnt=%b data=%h want 0001 f", gnt, data);
            errors++;
        end
`else
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0001 || data !== 4'h0) begin
            $display("FAIL zero_grant1: got gnt=%b data=%h want 0001 0", gnt, data);
            errors++;
        end
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0001 || data !== 4'h0) begin
            $display("FAIL zero_grant2: got gnt=%b data=%h want 0001 0", gnt, data);
            errors++;
        end
`endif
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        en  = 1'b1;
        req = 4'b0001;
        tick();
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0100 || data !== 4'hE) begin
            $display("FAIL midrst_grant: got gnt=%b data=%h want 0100 e", gnt, data);
            errors++;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || busy !== 1'b0 || grant_cnt !== 8'd0) begin
            $display("FAIL midrst_clear: got gnt=%b valid=%b busy=%b cnt=%0d want 0000 0 0 0", gnt, valid, busy, grant_cnt);
            errors++;
        end
        req = 4'b0101;
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0001 || data !== 4'hF) begin
            $display("FAIL midrst_after: got gnt=%b data=%h want 0001 f", gnt, data);
            errors++;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        en  = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                $display("FAIL en_block%0d: got gnt=%b busy=%b want 0000 0", i, gnt, busy);
                errors++;
            end
        end
        checks++;
        if (grant_cnt !== 8'd0) begin
            $display("FAIL en_cnt: got %0d want 0", grant_cnt);
            errors++;
        end
        en = 1'b1;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0001 || data !== 4'hF) begin
            $display("FAIL en_grant: got gnt=%b data=%h want 0001 f", gnt, data);
            errors++;
        end
        tick();
        tick();
        en = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0010 || data !== 4'hE) begin
            $display("FAIL en_complete: got gnt=%b data=%h want 0010 e", gnt, data);
            errors++;
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || grant_cnt !== 8'd2) begin
            $display("FAIL en_hold: got busy=%b cnt=%0d want 0 2", busy, grant_cnt);
            errors++;
        end
        req = 4'b0000;
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        req       = 4'b0000;
        seed_load = 1'b0;
        seed_val  = 4'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_seed_load();
        test_lockup();
        test_reset_mid_grant();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
